// File: rtl/gf4_div_seq.sv
// Sequential GF(2^4) divider: q = a * b^14 using one time-shared multiplier.
// Optional div_by_zero output is built when GF4_DIV_ZERO_FLAG_EN is defined.
module gf4_div_seq #(
    parameter logic [3:0] POLY = 4'b0011
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] q
`ifdef GF4_DIV_ZERO_FLAG_EN
    ,
    output logic       div_by_zero
`endif
);

    // Handshakes: a transfer happens on any rising edge where valid && ready
    // are both high; valid holds its payload stable until that edge.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXP  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] a_r;
    logic [3:0] b_r;
    logic [3:0] acc;
    logic [3:0] cnt;
    logic [3:0] mul_x;
    logic [3:0] mul_p;

    // Shift-and-add multiply, reducing by x^4+POLY after every shift.
    function automatic logic [3:0] gf_mul(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] p;
        p = 4'h0;
        for (int i = 3; i >= 0; i--) begin
            p = {p[2:0], 1'b0} ^ (p[3] ? POLY : 4'h0);
            if (y[i]) p = p ^ x;
        end
        return p;
    endfunction

    // The single multiplier: acc*b_r while exponentiating, acc*a_r for the final product.
    assign mul_x = (state == MUL) ? a_r : b_r;
    assign mul_p = gf_mul(acc, mul_x);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = EXP;
            EXP:  if (cnt == 4'd12) state_next = MUL;
            MUL:  state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r <= 4'h0;
            b_r <= 4'h0;
            acc <= 4'h0;
            cnt <= 4'h0;
            q   <= 4'h0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r <= a;
                    b_r <= b;
                    acc <= b;
                    cnt <= 4'h0;
                end
                EXP: begin
                    acc <= mul_p;
                    cnt <= cnt + 4'd1;
                end
                MUL: q <= mul_p;
                default: ;
            endcase
        end
    end

`ifdef GF4_DIV_ZERO_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst)                            div_by_zero <= 1'b0;
        else if (state == IDLE && in_valid) div_by_zero <= (b == 4'h0);
    end
`endif

endmodule

// File: tb/tb_gf4_div_seq.sv
// Self-checking bench for gf4_div_seq: vector table, exhaustive sweep,
// back-pressure, mid-operation reset and busy-input toggling.
module tb_gf4_div_seq;

    localparam logic [3:0] POLY = 4'b0011;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] q;
`ifdef GF4_DIV_ZERO_FLAG_EN
    logic       div_by_zero;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    gf4_div_seq #(.POLY(POLY)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q)
`ifdef GF4_DIV_ZERO_FLAG_EN
        ,
        .div_by_zero (div_by_zero)
`endif
    );

    always #5 clk = ~clk;

    // Reference: carry-less product as an integer, then polynomial long division.
    function automatic logic [3:0] ref_mul(input logic [3:0] x, input logic [3:0] y);
        int prod;
        int poly;
        prod = 0;
        poly = 16 | int'(POLY);
        for (int i = 0; i < 4; i++)
            if (y[i]) prod = prod ^ (int'(x) << i);
        for (int k = 7; k >= 4; k--)
            if (prod[k]) prod = prod ^ (poly << (k - 4));
        return prod[3:0];
    endfunction

    // Reference division: search for the inverse rather than exponentiating.
    function automatic logic [3:0] ref_div(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] c;
        if (y == 4'h0) return 4'h0;
        for (int i = 1; i < 16; i++) begin
            c = 4'(i);
            if (ref_mul(c, y) == 4'h1) return ref_mul(x, c);
        end
        return 4'hx;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation; reports quotient and edges from transfer to out_valid.
    task automatic run_op(input logic [3:0] av, input logic [3:0] bv, input int hold,
                          output logic [3:0] qv, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            step();
            w++;
        end
        chk("in_ready_before_op", int'(in_ready), 1);
        in_valid = 1'b1;
        a = av;
        b = bv;
        step();
        in_valid = 1'b0;
        a = $urandom_range(0, 15);
        b = $urandom_range(0, 15);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        qv = q;
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_out_valid", int'(out_valid), 1);
            chk("hold_q", int'(q), int'(qv));
            chk("hold_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("post_hs_in_ready", int'(in_ready), 1);
        chk("post_hs_out_valid", int'(out_valid), 0);
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
    } vec_t;

    vec_t             vecs[6];
    logic [3:0]       qv;
    logic [3:0]       exp_q[$];
    int               lat;

    initial begin
        vecs[0] = '{4'h2, 4'h3, 4'hF};
        vecs[1] = '{4'h1, 4'h2, 4'h9};
        vecs[2] = '{4'h5, 4'h5, 4'h1};
        vecs[3] = '{4'h0, 4'h7, 4'h0};
        vecs[4] = '{4'h9, 4'h0, 4'h0};
        vecs[5] = '{4'h1, 4'h1, 4'h1};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = 4'h0;
        b = 4'h0;
        step();
        step();
        rst = 1'b0;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_q", int'(q), 0);
`ifdef GF4_DIV_ZERO_FLAG_EN
        chk("reset_dbz", int'(div_by_zero), 0);
`endif

        // Table vectors with fixed latency check.
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, 0, qv, lat);
            chk("vec_latency", lat, 14);
            chk("vec_q", int'(qv), int'(vecs[i].q));
        end

        // Exhaustive sweep against the reference model.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                run_op(4'(ai), 4'(bi), 0, qv, lat);
                chk("sweep_q", int'(qv), int'(ref_div(4'(ai), 4'(bi))));
                if (bi != 0) chk("sweep_qb_eq_a", int'(ref_mul(qv, 4'(bi))), ai);
`ifdef GF4_DIV_ZERO_FLAG_EN
                chk("sweep_dbz", int'(div_by_zero), int'(bi == 0));
`endif
            end
        end

        // Back-pressure: 20 cycles held in DONE.
        run_op(4'h6, 4'hB, 20, qv, lat);
        chk("bp_latency", lat, 14);
        chk("bp_q", int'(qv), int'(ref_div(4'h6, 4'hB)));

        // Reset at the 5th EXP cycle aborts the operation.
        in_valid = 1'b1;
        a = 4'h7;
        b = 4'h3;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_q", int'(q), 0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 30; i++) begin
                step();
                if (out_valid) seen++;
            end
            chk("abort_no_output", seen, 0);
        end
        out_ready = 1'b0;

        // Operands and in_valid/out_ready churn while busy.
        begin
            logic [3:0] ca;
            logic [3:0] cb;
            int         extra;
            int         n;
            ca = 4'(($urandom % 15) + 1);
            cb = 4'(($urandom % 15) + 1);
            in_valid = 1'b1;
            a = ca;
            b = cb;
            step();
            exp_q.push_back(ref_div(ca, cb));
            extra = 0;
            n = 0;
            while (!out_valid && n < 40) begin
                if (in_ready) extra++;
                a = $urandom_range(0, 15);
                b = $urandom_range(0, 15);
                out_ready = 1'($urandom_range(0, 1));
                step();
                n++;
            end
            out_ready = 1'b0;
            in_valid = 1'b0;
            chk("busy_latency", n, 14);
            chk("busy_extra_transfer", extra, 0);
            chk("busy_q", int'(q), int'(exp_q.pop_front()));
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk("busy_post_in_ready", int'(in_ready), 1);
        end

        // Random operations with random back-pressure.
        for (int i = 0; i < 20; i++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            exp_q.push_back(ref_div(ra, rb));
            run_op(ra, rb, int'($urandom_range(0, 3)), qv, lat);
            chk("rand_latency", lat, 14);
            chk("rand_q", int'(qv), int'(exp_q.pop_front()));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
